isp_2dnr_cfg: RTL and testbench
===============================

ISP_2DNR_CFG -- requirements
Module: isp_2dnr_cfg

Interface
REQ-001 SHALL have parameter BITS, default 8, pixel / difference-threshold width.
REQ-002 SHALL have parameter WEIGHT_BITS, default 5, range-kernel weight width.
REQ-003 SHALL have parameter LUT_SIZE, default 15, number of difference/weight LUT entries (2..16).
REQ-004 SHALL have port pclk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port in_vsync, input, 1, frame sync of the pixel stream feeding the 2DNR datapath.
REQ-007 SHALL have port cfg_wr, input, 1, register-write strobe.
REQ-008 SHALL have port cfg_addr, input, 5, write address.
REQ-009 SHALL have port cfg_wdata, input, BITS, write data.
REQ-010 SHALL have port cfg_commit, input, 1, request to validate the shadow tables and apply them at the next frame boundary.
REQ-011 SHALL have port diff_value, output, LUT_SIZE*BITS, active difference table; entry k at bits [BITS*k +: BITS].
REQ-012 SHALL have port weight, output, LUT_SIZE*WEIGHT_BITS, active weight table; entry k at bits [WEIGHT_BITS*k +: WEIGHT_BITS].
REQ-013 SHALL have port cfg_state, output, 2, FSM state: 0 IDLE, 1 CHECK, 2 ARMED.
REQ-014 SHALL have port cfg_wr_rej, output, 1, one-cycle pulse when a write is rejected.
REQ-015 SHALL have port cfg_err, output, 1, sticky flag set when the shadow difference table is non-monotonic.
REQ-016 SHALL have port cfg_applied, output, 1, one-cycle pulse when the shadow tables are copied to the active tables.
REQ-017 SHALL have port frame_cnt, output, 16, count of in_vsync rising edges.

Function
REQ-018 SHALL map addresses 0..LUT_SIZE-1 to shadow diff[addr], which takes the full cfg_wdata.
REQ-019 SHALL map addresses 16..16+LUT_SIZE-1 to shadow weight[addr-16], which takes cfg_wdata[WEIGHT_BITS-1:0].
REQ-020 SHALL reject a write (no shadow change; cfg_wr_rej high the next cycle) if the address is unmapped or the state is not IDLE.
REQ-021 SHALL detect a vsync rising edge as in_vsync=1 with the registered previous in_vsync=0.
REQ-022 SHALL make the IDLE transition: cfg_commit=1 -> CHECK, idx=0, cfg_err cleared; a write in the same cycle is applied first and included in the check.
REQ-023 SHALL, in CHECK, compare shadow diff[idx] with diff[idx+1] each cycle, requiring diff[idx] <= diff[idx+1] (unsigned), then increment idx.
REQ-024 SHALL leave CHECK after the idx=LUT_SIZE-2 compare (CHECK lasts exactly LUT_SIZE-1 cycles): go to ARMED if all compares passed, else set cfg_err and return to IDLE.
REQ-025 SHALL, in ARMED on a vsync rising edge, copy all shadow entries to the active tables in one cycle, pulse cfg_applied that cycle, and go to IDLE.
REQ-026 SHALL not hold vsync edges occurring in IDLE or CHECK; ARMED waits for the next edge.
REQ-027 SHALL ignore cfg_commit in CHECK and ARMED.
REQ-028 SHALL change the active tables only on the cfg_applied cycle, never mid-frame.
REQ-029 SHALL increment frame_cnt on every vsync rising edge in any state, wrapping 0xFFFF -> 0.
REQ-030 SHALL keep the shadow tables unchanged by a failed check; the firmware rewrites and recommits.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, set state IDLE, idx 0, cfg_err 0, cfg_wr_rej 0, cfg_applied 0, frame_cnt 0, and the registered previous vsync to 0.
REQ-032 SHALL, on reset, set shadow and active diff[k] = 4*k and shadow and active weight[k] = LUT_SIZE-1-k (k = 0..LUT_SIZE-1).
REQ-033 SHALL let reset during CHECK or ARMED abandon the pending commit, with no apply.

Verification
REQ-034 SHALL test: after reset, check diff_value entry 3 = 12 and weight entry 0 = 14 (defaults); then write addr 2 = 9, commit, raise vsync -> cfg_state reads 1 for 14 cycles then 2; cfg_applied pulses on the vsync edge; diff entry 2 = 9.
REQ-035 SHALL test: write diff[5]=50 and diff[6]=40, then commit -> cfg_err=1 after 14 cycles; state IDLE; active tables unchanged; no cfg_applied on the next vsync.
REQ-036 SHALL test: in ARMED, write addr 17 -> cfg_wr_rej pulses and shadow weight[1] is unchanged; write addr 15 or 31 while IDLE -> cfg_wr_rej pulses.
REQ-037 SHALL test: commit while a vsync edge lands in CHECK -> no apply on that edge; apply on the following edge; frame_cnt counts both edges.
REQ-038 SHALL test: rst_n=0 asserted while ARMED, then a vsync edge -> no cfg_applied, tables at defaults, frame_cnt=1.
REQ-039 SHALL test: preload frame_cnt to 0xFFFF by 65535 edges, one more edge -> frame_cnt=0.

Source files
------------

// File: rtl/isp_2dnr_cfg.sv
// 2DNR difference/weight LUT config: shadow tables are validated for monotonic differences,
// then swapped into the active tables on the next vsync rising edge (never mid-frame).
module isp_2dnr_cfg #(
  parameter int BITS        = 8,
  parameter int WEIGHT_BITS = 5,
  parameter int LUT_SIZE    = 15
) (
  input  logic                            pclk,
  input  logic                            rst_n,
  input  logic                            in_vsync,
  input  logic                            cfg_wr,
  input  logic [4:0]                      cfg_addr,
  input  logic [BITS-1:0]                 cfg_wdata,
  input  logic                            cfg_commit,
  output logic [LUT_SIZE*BITS-1:0]        diff_value,
  output logic [LUT_SIZE*WEIGHT_BITS-1:0] weight,
  output logic [1:0]                      cfg_state,
  output logic                            cfg_wr_rej,
  output logic                            cfg_err,
  output logic                            cfg_applied,
  output logic [15:0]                     frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  localparam logic [4:0] LUT_N    = 5'(LUT_SIZE);
  localparam logic [3:0] IDX_LAST = 4'(LUT_SIZE - 2);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_idx;
  logic                   r_chk_ok;
  logic                   r_err;
  logic                   r_wr_rej;
  logic                   r_applied;
  logic [15:0]            r_frame_cnt;
  logic                   r_vsync_d;
  logic [BITS-1:0]        r_sh_diff  [LUT_SIZE];
  logic [WEIGHT_BITS-1:0] r_sh_wt    [LUT_SIZE];
  logic [BITS-1:0]        r_act_diff [LUT_SIZE];
  logic [WEIGHT_BITS-1:0] r_act_wt   [LUT_SIZE];

  logic w_addr_ok, w_wr_ok, w_wr_diff, w_wr_wt, w_vs_rise, w_cmp_ok;
  logic w_start, w_chk_done, w_apply;

  // Bit 4 selects the weight bank; the low nibble must land inside the LUT.
  assign w_addr_ok = ({1'b0, cfg_addr[3:0]} < LUT_N);
  assign w_wr_ok   = cfg_wr && (r_state == S_IDLE) && w_addr_ok;
  assign w_wr_diff = w_wr_ok && !cfg_addr[4];
  assign w_wr_wt   = w_wr_ok && cfg_addr[4];
  assign w_vs_rise = in_vsync && !r_vsync_d;
  assign w_cmp_ok  = (r_sh_diff[r_idx] <= r_sh_diff[r_idx + 4'd1]);

  always_ff @(posedge pclk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_chk_done  = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_commit) begin
          w_start     = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_idx == IDX_LAST) begin
          w_chk_done  = 1'b1;
          w_state_nxt = (r_chk_ok && w_cmp_ok) ? S_ARMED : S_IDLE;
        end
      end
      S_ARMED: begin
        if (w_vs_rise) begin
          w_apply     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_idx       <= 4'd0;
      r_chk_ok    <= 1'b1;
      r_err       <= 1'b0;
      r_wr_rej    <= 1'b0;
      r_applied   <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_vsync_d   <= 1'b0;
    end else begin
      r_vsync_d <= in_vsync;
      r_wr_rej  <= cfg_wr && !w_wr_ok;
      r_applied <= w_apply;
      if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_start) begin
        r_idx    <= 4'd0;
        r_chk_ok <= 1'b1;
        r_err    <= 1'b0;
      end else if (r_state == S_CHECK) begin
        r_idx    <= r_idx + 4'd1;
        r_chk_ok <= r_chk_ok && w_cmp_ok;
        if (w_chk_done && !(r_chk_ok && w_cmp_ok)) r_err <= 1'b1;
      end
    end
  end

  // Active tables follow the shadow only on the apply cycle.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      for (int k = 0; k < LUT_SIZE; k++) begin
        r_sh_diff[k]  <= BITS'(4 * k);
        r_act_diff[k] <= BITS'(4 * k);
        r_sh_wt[k]    <= WEIGHT_BITS'(LUT_SIZE - 1 - k);
        r_act_wt[k]   <= WEIGHT_BITS'(LUT_SIZE - 1 - k);
      end
    end else begin
      if (w_wr_diff) r_sh_diff[cfg_addr[3:0]] <= cfg_wdata;
      if (w_wr_wt)   r_sh_wt[cfg_addr[3:0]]   <= cfg_wdata[WEIGHT_BITS-1:0];
      if (w_apply) begin
        r_act_diff <= r_sh_diff;
        r_act_wt   <= r_sh_wt;
      end
    end
  end

  for (genvar g = 0; g < LUT_SIZE; g++) begin : g_pack
    assign diff_value[BITS*g +: BITS]             = r_act_diff[g];
    assign weight[WEIGHT_BITS*g +: WEIGHT_BITS]   = r_act_wt[g];
  end

  assign cfg_state   = r_state;
  assign cfg_wr_rej  = r_wr_rej;
  assign cfg_err     = r_err;
  assign cfg_applied = r_applied;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_isp_2dnr_cfg.sv
// Directed bench for isp_2dnr_cfg: writes, commit/check timing, rejects, vsync
// alignment, reset abandonment and frame counter wrap.
module tb_isp_2dnr_cfg;

  logic         pclk;
  logic         rst_n;
  logic         in_vsync;
  logic         cfg_wr;
  logic [4:0]   cfg_addr;
  logic [7:0]   cfg_wdata;
  logic         cfg_commit;
  logic [119:0] diff_value;
  logic [74:0]  weight;
  logic [1:0]   cfg_state;
  logic         cfg_wr_rej;
  logic         cfg_err;
  logic         cfg_applied;
  logic [15:0]  frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  isp_2dnr_cfg #(.BITS(8), .WEIGHT_BITS(5), .LUT_SIZE(15)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .in_vsync    (in_vsync),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit),
    .diff_value  (diff_value),
    .weight      (weight),
    .cfg_state   (cfg_state),
    .cfg_wr_rej  (cfg_wr_rej),
    .cfg_err     (cfg_err),
    .cfg_applied (cfg_applied),
    .frame_cnt   (frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] dv(input int k);
    return {24'd0, diff_value[8*k +: 8]};
  endfunction

  function automatic logic [31:0] wt(input int k);
    return {27'd0, weight[5*k +: 5]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_wr    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_vsync = 1'b0; cfg_wr = 1'b0;
    cfg_addr = 5'd0; cfg_wdata = 8'd0; cfg_commit = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_state", cfg_state, 0);
    check("rst_err", cfg_err, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_applied", cfg_applied, 0);
    check("rst_wr_rej", cfg_wr_rej, 0);
    check("rst_diff3", dv(3), 12);
    check("rst_diff14", dv(14), 56);
    check("rst_wt0", wt(0), 14);
    check("rst_wt14", wt(14), 0);

    // Good commit: CHECK spans 14 cycles, apply lands on the vsync edge.
    wr(5'd2, 8'd9);
    check("wr2_rej", cfg_wr_rej, 0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("check_state", cfg_state, 1);
      step();
    end
    check("armed_state", cfg_state, 2);
    check("armed_diff2_old", dv(2), 8);
    in_vsync = 1'b1;
    step();
    check("apply_pulse", cfg_applied, 1);
    check("apply_diff2", dv(2), 9);
    check("apply_state", cfg_state, 0);
    check("apply_frame", frame_cnt, 1);
    in_vsync = 1'b0;
    step();
    check("apply_pulse_end", cfg_applied, 0);

    // Non-monotonic shadow: error, tables kept, no apply.
    wr(5'd5, 8'd50);
    wr(5'd6, 8'd40);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("bad_state0", cfg_state, 1);
    repeat (13) step();
    check("bad_err_late", cfg_err, 0);
    step();
    check("bad_err", cfg_err, 1);
    check("bad_state", cfg_state, 0);
    check("bad_diff5", dv(5), 20);
    check("bad_diff6", dv(6), 24);
    in_vsync = 1'b1;
    step();
    check("bad_no_apply", cfg_applied, 0);
    check("bad_frame", frame_cnt, 2);
    check("bad_diff5_vs", dv(5), 20);
    in_vsync = 1'b0;
    step();

    // Repair, re-arm, then try a write while ARMED.
    wr(5'd5, 8'd20);
    wr(5'd6, 8'd24);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("recommit_err_clr", cfg_err, 0);
    repeat (14) step();
    check("rearm_state", cfg_state, 2);
    wr(5'd17, 8'd31);
    check("armed_wr_rej", cfg_wr_rej, 1);
    step();
    check("armed_wr_rej_end", cfg_wr_rej, 0);
    in_vsync = 1'b1;
    step();
    check("rearm_apply", cfg_applied, 1);
    check("rearm_wt1", wt(1), 13);
    check("rearm_frame", frame_cnt, 3);
    in_vsync = 1'b0;
    step();
    wr(5'd15, 8'hAA);
    check("idle_wr15_rej", cfg_wr_rej, 1);
    wr(5'd31, 8'hAA);
    check("idle_wr31_rej", cfg_wr_rej, 1);

    // Vsync edge during CHECK is dropped; the next one applies.
    wr(5'd30, 8'd7);
    check("wr30_rej", cfg_wr_rej, 0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step(); step();
    in_vsync = 1'b1;
    step();
    check("chk_vs_no_apply", cfg_applied, 0);
    check("chk_vs_frame", frame_cnt, 4);
    check("chk_vs_state", cfg_state, 1);
    in_vsync = 1'b0;
    repeat (11) step();
    check("chk_vs_armed", cfg_state, 2);
    check("chk_vs_wt14_old", wt(14), 0);
    in_vsync = 1'b1;
    step();
    check("chk_vs_apply", cfg_applied, 1);
    check("chk_vs_wt14", wt(14), 7);
    check("chk_vs_diff2", dv(2), 9);
    check("chk_vs_frame2", frame_cnt, 5);
    in_vsync = 1'b0;
    step();

    // Reset while ARMED abandons the commit.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    repeat (14) step();
    check("rst_armed_state", cfg_state, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_armed_idle", cfg_state, 0);
    check("rst_armed_frame0", frame_cnt, 0);
    in_vsync = 1'b1;
    step();
    check("rst_armed_no_apply", cfg_applied, 0);
    check("rst_armed_frame1", frame_cnt, 1);
    check("rst_armed_wt14", wt(14), 0);
    check("rst_armed_diff2", dv(2), 8);
    in_vsync = 1'b0;
    step();

    // Jump the counter near wrap rather than spending 65534 edges on it.
    force dut.r_frame_cnt = 16'hFFFE;
    step();
    release dut.r_frame_cnt;
    in_vsync = 1'b1;
    step();
    check("frame_ffff", frame_cnt, 16'hFFFF);
    in_vsync = 1'b0;
    step();
    in_vsync = 1'b1;
    step();
    check("frame_wrap", frame_cnt, 0);
    in_vsync = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
